// File: rtl/dcf77_tone_if.sv
// Sample-stream bundle between the tone generator and its consumer.
// The master side drives the run/key requests; the slave side produces samples.
interface dcf77_tone_if;
  logic               enable;
  logic               key;
  logic signed [31:0] sample;
  logic               sample_valid;
  logic               block_start;
  logic               overflow;

  modport master (
    output enable, key,
    input  sample, sample_valid, block_start, overflow
  );

  modport slave (
    input  enable, key,
    output sample, sample_valid, block_start, overflow
  );
endinterface

// File: rtl/dcf77_tone_gen.sv
// Block-keyed 77.5 kHz carrier synthesiser using the Goertzel oscillator recursion in Q2.30.
// Each block restarts the phase from a full-scale or keyed-down seed.
module dcf77_tone_gen #(
  parameter int                 BLOCK_LEN = 520,
  parameter logic signed [31:0] COEFF     = 32'sd1998584398,
  parameter logic signed [31:0] SEED_HIGH = 32'sd100000000,
  parameter logic signed [31:0] SEED_LOW  = 32'sd15000000
) (
  input  logic         clock_sample,
  input  logic         reset_n,
  dcf77_tone_if.slave  tone
);

  localparam int            CW   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic signed [31:0] p1, p1_d, p2, p2_d;
  logic signed [31:0] sample_q, sample_d;
  logic               valid_q, valid_d, bs_q, bs_d, ov_q, ov_d;

  logic signed [63:0] prod, t;
  logic signed [31:0] y, seed;
  logic               sat;

  // One oscillator step: y = floor(COEFF*p1 / 2^30) - p2, clamped to 32 bits.
  always_comb begin
    prod = $signed({{32{COEFF[31]}}, COEFF}) * $signed({{32{p1[31]}}, p1});
    t    = (prod >>> 30) - $signed({{32{p2[31]}}, p2});
    sat  = 1'b0;
    y    = t[31:0];
    if (t > SAT_MAX) begin
      y   = 32'sh7FFF_FFFF;
      sat = 1'b1;
    end else if (t < SAT_MIN) begin
      y   = 32'sh8000_0000;
      sat = 1'b1;
    end
  end

  assign seed = tone.key ? SEED_LOW : SEED_HIGH;

  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the case can infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    p1_d     = p1;
    p2_d     = p2;
    sample_d = sample_q;
    valid_d  = valid_q;
    bs_d     = bs_q;
    ov_d     = ov_q;

    if (state == RUN && cnt != LAST) begin
      sample_d = y;
      p2_d     = p1;
      p1_d     = y;
      cnt_d    = cnt + CW'(1);
      bs_d     = 1'b0;
      ov_d     = ov_q | sat;
    end else if (tone.enable) begin
      // Block boundary (or idle) with a run request: restart phase from the seed.
      state_d  = RUN;
      sample_d = seed;
      p1_d     = seed;
      p2_d     = '0;
      cnt_d    = '0;
      valid_d  = 1'b1;
      bs_d     = 1'b1;
    end else if (state == RUN) begin
      state_d  = IDLE;
      sample_d = '0;
      valid_d  = 1'b0;
      bs_d     = 1'b0;
    end
  end

  always_ff @(posedge clock_sample) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      p1       <= '0;
      p2       <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      bs_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      p1       <= p1_d;
      p2       <= p2_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      bs_q     <= bs_d;
      ov_q     <= ov_d;
    end
  end

  assign tone.sample       = sample_q;
  assign tone.sample_valid = valid_q;
  assign tone.block_start  = bs_q;
  assign tone.overflow     = ov_q;

endmodule

// File: tb/tb_dcf77_tone_gen.sv
// Directed bench for dcf77_tone_gen: several parameterisations share one clock and reset,
// each exercised by its own task with hand-computed expected samples.
module tb_dcf77_tone_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  dcf77_tone_if if_q ();
  dcf77_tone_if if_s ();
  dcf77_tone_if if_o ();
  dcf77_tone_if if_f ();
  dcf77_tone_if if_d ();

  // Quarter-rate tone (COEFF = 0), also used for keying and stop/restart.
  dcf77_tone_gen #(.BLOCK_LEN(8), .COEFF(32'sd0), .SEED_HIGH(32'sd1000), .SEED_LOW(32'sd150))
    u_q (.clock_sample(clk), .reset_n(reset_n), .tone(if_q));
  // Sixth-rate tone (COEFF = 1.0).
  dcf77_tone_gen #(.BLOCK_LEN(6), .COEFF(32'sh4000_0000), .SEED_HIGH(32'sd1000), .SEED_LOW(32'sd150))
    u_s (.clock_sample(clk), .reset_n(reset_n), .tone(if_s));
  // Saturating oscillator.
  dcf77_tone_gen #(.BLOCK_LEN(8), .COEFF(32'sh7FFF_FFFF), .SEED_HIGH(32'sh4000_0000), .SEED_LOW(32'sd150))
    u_o (.clock_sample(clk), .reset_n(reset_n), .tone(if_o));
  // COEFF = 0.5 with a small odd seed exposes floor versus truncate/round.
  dcf77_tone_gen #(.BLOCK_LEN(8), .COEFF(32'sh2000_0000), .SEED_HIGH(32'sd3), .SEED_LOW(32'sd150))
    u_f (.clock_sample(clk), .reset_n(reset_n), .tone(if_f));
  // Default parameters.
  dcf77_tone_gen u_d (.clock_sample(clk), .reset_n(reset_n), .tone(if_d));

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    if_q.enable = 1'b0; if_q.key = 1'b0;
    if_s.enable = 1'b0; if_s.key = 1'b0;
    if_o.enable = 1'b0; if_o.key = 1'b0;
    if_f.enable = 1'b0; if_f.key = 1'b0;
    if_d.enable = 1'b0; if_d.key = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({if_q.sample, if_q.sample_valid, if_q.block_start, if_q.overflow} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_q: got sample=%0d valid=%b bs=%b ov=%b, want all 0",
               if_q.sample, if_q.sample_valid, if_q.block_start, if_q.overflow);
    end
    tests_run++;
    if ({if_o.sample, if_o.sample_valid, if_o.block_start, if_o.overflow} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_o: got sample=%0d valid=%b bs=%b ov=%b, want all 0",
               if_o.sample, if_o.sample_valid, if_o.block_start, if_o.overflow);
    end
    tests_run++;
    if ({if_d.sample, if_d.sample_valid, if_d.block_start, if_d.overflow} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_d: got sample=%0d valid=%b bs=%b ov=%b, want all 0",
               if_d.sample, if_d.sample_valid, if_d.block_start, if_d.overflow);
    end
  endtask

  task automatic test_quarter();
    logic signed [31:0] pat [4] = '{32'sd1000, 32'sd0, -32'sd1000, 32'sd0};
    do_reset();
    if_q.enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests_run++;
      if ({if_q.sample, if_q.sample_valid, if_q.block_start} !== {pat[i%4], 1'b1, (i % 8 == 0)}) begin
        tests_failed++;
        $display("FAIL quarter[%0d]: got sample=%0d valid=%b bs=%b, want sample=%0d valid=1 bs=%b",
                 i, if_q.sample, if_q.sample_valid, if_q.block_start, pat[i%4], (i % 8 == 0));
      end
    end
    if_q.enable = 1'b0;
  endtask

  task automatic test_sixth();
    logic signed [31:0] pat [6] = '{32'sd1000, 32'sd1000, 32'sd0, -32'sd1000, -32'sd1000, 32'sd0};
    do_reset();
    if_s.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests_run++;
      if ({if_s.sample, if_s.block_start, if_s.overflow} !== {pat[i%6], (i % 6 == 0), 1'b0}) begin
        tests_failed++;
        $display("FAIL sixth[%0d]: got sample=%0d bs=%b ov=%b, want sample=%0d bs=%b ov=0",
                 i, if_s.sample, if_s.block_start, if_s.overflow, pat[i%6], (i % 6 == 0));
      end
    end
    if_s.enable = 1'b0;
  endtask

  task automatic test_keying();
    logic signed [31:0] exp_s;
    do_reset();
    if_q.enable = 1'b1;
    if_q.key    = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      case (i % 4)
        0:       exp_s = (i >= 8 && i < 16) ? 32'sd150  : 32'sd1000;
        2:       exp_s = (i >= 8 && i < 16) ? -32'sd150 : -32'sd1000;
        default: exp_s = 32'sd0;
      endcase
      tests_run++;
      if ({if_q.sample, if_q.block_start} !== {exp_s, (i % 8 == 0)}) begin
        tests_failed++;
        $display("FAIL keying[%0d]: got sample=%0d bs=%b, want sample=%0d bs=%b",
                 i, if_q.sample, if_q.block_start, exp_s, (i % 8 == 0));
      end
      // Key rises mid-block 1 (held through block 2 start), falls mid-block 2.
      if (i == 2)  if_q.key = 1'b1;
      if (i == 10) if_q.key = 1'b0;
    end
    if_q.enable = 1'b0;
  endtask

  task automatic test_stop_restart();
    logic signed [31:0] pat [4] = '{32'sd1000, 32'sd0, -32'sd1000, 32'sd0};
    do_reset();
    if_q.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if ({if_q.sample, if_q.sample_valid} !== {pat[i%4], 1'b1}) begin
        tests_failed++;
        $display("FAIL stop_block[%0d]: got sample=%0d valid=%b, want sample=%0d valid=1",
                 i, if_q.sample, if_q.sample_valid, pat[i%4]);
      end
      if (i == 3) if_q.enable = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({if_q.sample, if_q.sample_valid, if_q.block_start} !== 34'd0) begin
        tests_failed++;
        $display("FAIL stop_idle[%0d]: got sample=%0d valid=%b bs=%b, want all 0",
                 i, if_q.sample, if_q.sample_valid, if_q.block_start);
      end
    end
    if_q.enable = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({if_q.sample, if_q.sample_valid, if_q.block_start} !== {32'sd1000, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL restart: got sample=%0d valid=%b bs=%b, want sample=1000 valid=1 bs=1",
               if_q.sample, if_q.sample_valid, if_q.block_start);
    end
    if_q.enable = 1'b0;
  endtask

  task automatic test_saturation();
    logic signed [31:0] pat [3] = '{32'sh4000_0000, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
    do_reset();
    if_o.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({if_o.sample, if_o.overflow} !== {pat[i], (i == 2)}) begin
        tests_failed++;
        $display("FAIL sat[%0d]: got sample=%h ov=%b, want sample=%h ov=%b",
                 i, if_o.sample, if_o.overflow, pat[i], (i == 2));
      end
    end
    if_o.enable = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if ({if_o.sample_valid, if_o.overflow} !== 2'b01) begin
      tests_failed++;
      $display("FAIL sat_sticky: got valid=%b ov=%b, want valid=0 ov=1",
               if_o.sample_valid, if_o.overflow);
    end
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (if_o.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clear: got ov=%b, want ov=0", if_o.overflow);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_floor();
    logic signed [31:0] pat [5] = '{32'sd3, 32'sd1, -32'sd3, -32'sd3, 32'sd1};
    do_reset();
    if_f.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (if_f.sample !== pat[i]) begin
        tests_failed++;
        $display("FAIL floor[%0d]: got sample=%0d, want %0d", i, if_f.sample, pat[i]);
      end
    end
    if_f.enable = 1'b0;
  endtask

  task automatic test_default_reset_mid_block();
    int bs_errs;
    do_reset();
    if_d.enable = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({if_d.sample, if_d.block_start} !== {32'sd100000000, 1'b1}) begin
      tests_failed++;
      $display("FAIL dflt_first: got sample=%0d bs=%b, want sample=100000000 bs=1",
               if_d.sample, if_d.block_start);
    end
    @(negedge clk);
    tests_run++;
    if ({if_d.sample, if_d.block_start} !== {32'sd186132676, 1'b0}) begin
      tests_failed++;
      $display("FAIL dflt_second: got sample=%0d bs=%b, want sample=186132676 bs=0",
               if_d.sample, if_d.block_start);
    end
    repeat (299) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({if_d.sample, if_d.sample_valid, if_d.block_start, if_d.overflow} !== 35'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got sample=%0d valid=%b bs=%b ov=%b, want all 0",
               if_d.sample, if_d.sample_valid, if_d.block_start, if_d.overflow);
    end
    reset_n = 1'b1;
    bs_errs = 0;
    for (int i = 0; i < 1041; i++) begin
      @(negedge clk);
      if ({if_d.sample_valid, if_d.block_start} !== {1'b1, (i % 520 == 0)}) begin
        if (bs_errs < 4)
          $display("FAIL dflt_period[%0d]: got valid=%b bs=%b, want valid=1 bs=%b",
                   i, if_d.sample_valid, if_d.block_start, (i % 520 == 0));
        bs_errs++;
      end
      if (i == 0) begin
        tests_run++;
        if (if_d.sample !== 32'sd100000000) begin
          tests_failed++;
          $display("FAIL dflt_restart: got sample=%0d, want 100000000", if_d.sample);
        end
      end
    end
    tests_run++;
    if (bs_errs != 0) begin
      tests_failed++;
      $display("FAIL dflt_period_total: got %0d bad cycles, want 0", bs_errs);
    end
    if_d.enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_quarter();
    test_sixth();
    test_keying();
    test_stop_restart();
    test_saturation();
    test_floor();
    test_default_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
